// File: rtl/sipo_pkg.sv
// Shared types and sizing helpers for the serial-to-parallel deserializer.
package sipo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } sipo_state_e;

  localparam int SIPO_WIDTH_DEF = 4;

  // Bit counter must be able to represent 0..WIDTH.
  function automatic int sipo_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int SIPO_CNT_W = sipo_cnt_w(SIPO_WIDTH_DEF);

endpackage

// File: rtl/sipo_hold_reg.sv
// Output holding register: accepts a completed word one edge after its last bit.
// A word arriving while an undelivered one is held and not being taken is dropped and flagged.
module sipo_hold_reg
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_vld,
  input  logic [WIDTH-1:0] load_dat,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  input  logic             dout_rdy,
  output logic             overrun,
  input  logic             clr_ovr
);

  logic [WIDTH-1:0] dout_d, dout_q;
  logic             dout_vld_d, dout_vld_q;
  logic             overrun_d, overrun_q;
  logic             drop;

  always_comb begin
    dout_d     = dout_q;
    dout_vld_d = dout_vld_q;
    drop       = 1'b0;
    if (load_vld) begin
      // Slot is free if empty or being drained this same edge.
      if (!dout_vld_q || dout_rdy) begin
        dout_d     = load_dat;
        dout_vld_d = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end else if (dout_vld_q && dout_rdy) begin
      dout_vld_d = 1'b0;
    end
    overrun_d = drop ? 1'b1 : (clr_ovr ? 1'b0 : overrun_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      overrun_q  <= overrun_d;
    end
  end

  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
  assign overrun  = overrun_q;

endmodule

// File: rtl/sipo_deser.sv
// MSB-first serial-to-parallel deserializer with start-of-frame resync.
// Word is valid one cycle after its last bit; a full held word with no ready drops the new one.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_vld,
  input  logic             sof,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  input  logic             dout_rdy,
  output logic             busy,
  output logic             overrun,
  input  logic             clr_ovr
);

  localparam int CNT_W = sipo_cnt_w(WIDTH);

  sipo_state_e      state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  // Only WIDTH-1 bits need storing; the last bit comes straight from sin.
  logic [WIDTH-2:0] shreg_d, shreg_q;
  logic             busy_d, busy_q;
  logic [WIDTH-1:0] word;
  logic             word_done;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    word      = {shreg_q, sin};
    word_done = 1'b0;
    if (sin_vld) begin
      if (sof) begin
        shreg_d = (WIDTH-1)'(sin);
        cnt_d   = CNT_W'(1);
        state_d = SHIFT;
      end else begin
        shreg_d = word[WIDTH-2:0];
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          word_done = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = SHIFT;
        end
      end
    end
    busy_d = (state_d == SHIFT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;

  sipo_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk     (clk),
    .rst     (rst),
    .load_vld(word_done),
    .load_dat(word),
    .dout    (dout),
    .dout_vld(dout_vld),
    .dout_rdy(dout_rdy),
    .overrun (overrun),
    .clr_ovr (clr_ovr)
  );

endmodule

// File: tb/tb_sipo_deser.sv
// Scoreboard bench for sipo_deser at WIDTH=4: expected words queued at stimulus, checked on handshake.
module tb_sipo_deser;

  logic       clk = 1'b0;
  logic       rst;
  logic       sin;
  logic       sin_vld;
  logic       sof;
  logic [3:0] dout;
  logic       dout_vld;
  logic       dout_rdy;
  logic       busy;
  logic       overrun;
  logic       clr_ovr;

  int n_vec  = 0;
  int n_miss = 0;
  int busy_cnt = 0;
  int vld_cnt  = 0;
  logic [3:0] sb[$];

  sipo_deser #(.WIDTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .sin     (sin),
    .sin_vld (sin_vld),
    .sof     (sof),
    .dout    (dout),
    .dout_vld(dout_vld),
    .dout_rdy(dout_rdy),
    .busy    (busy),
    .overrun (overrun),
    .clr_ovr (clr_ovr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: sample mid-cycle; a handshake here completes at the next edge.
  always @(negedge clk) begin
    if (busy === 1'b1) busy_cnt++;
    if (dout_vld === 1'b1) vld_cnt++;
    if (!rst && dout_vld && dout_rdy) begin
      if (sb.size() == 0) chk("sb_unexpected_vld", 32'(dout_vld), 32'(0));
      else chk("sb_word", 32'(dout), 32'(sb.pop_front()));
    end
  end

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic probe();
    @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input logic s);
    go();
    sin     = b;
    sin_vld = 1'b1;
    sof     = s;
  endtask

  // Idle cycles carry garbage sin and sof: both must be ignored without sin_vld.
  task automatic idle(input int n);
    repeat (n) begin
      go();
      sin_vld = 1'b0;
      sof     = 1'b1;
      sin     = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send_frame(input logic [3:0] w, input logic use_sof);
    for (int i = 3; i >= 0; i--) send_bit(w[i], (i == 3) ? use_sof : 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sin = 1'b0; sin_vld = 1'b0; sof = 1'b0; dout_rdy = 1'b1; clr_ovr = 1'b0;
    go(); go();
    rst = 1'b0;
    probe();
    chk("rst_dout", 32'(dout), 32'(0));
    chk("rst_vld", 32'(dout_vld), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_ovr", 32'(overrun), 32'(0));

    // Basic frame, consumer always ready.
    busy_cnt = 0; vld_cnt = 0;
    sb.push_back(4'hB);
    send_frame(4'hB, 1'b1);
    probe();
    chk("t1_vld_before_edge", 32'(dout_vld), 32'(0));
    idle(1);
    probe();
    chk("t1_vld_after_edge", 32'(dout_vld), 32'(1));
    chk("t1_dout", 32'(dout), 32'(4'hB));
    idle(4);
    chk("t1_busy_cycles", 32'(busy_cnt), 32'(3));
    chk("t1_vld_cycles", 32'(vld_cnt), 32'(1));

    // Gapped bits: state must hold across idle cycles.
    busy_cnt = 0; vld_cnt = 0;
    sb.push_back(4'h6);
    send_bit(1'b0, 1'b1); idle(2);
    send_bit(1'b1, 1'b0); idle(2);
    send_bit(1'b1, 1'b0); idle(2);
    send_bit(1'b0, 1'b0);
    go();
    chk("t2_no_early_vld", 32'(vld_cnt), 32'(0));
    sin_vld = 1'b0; sof = 1'b0;
    idle(4);
    chk("t2_busy_cycles", 32'(busy_cnt), 32'(9));
    chk("t2_vld_cycles", 32'(vld_cnt), 32'(1));

    // Back-to-back frames with no consumer: second is dropped.
    dout_rdy = 1'b0;
    sb.push_back(4'hB);
    send_frame(4'hB, 1'b1);
    send_frame(4'h6, 1'b1);
    idle(1);
    probe();
    chk("t3_dout_held", 32'(dout), 32'(4'hB));
    chk("t3_vld_held", 32'(dout_vld), 32'(1));
    chk("t3_overrun", 32'(overrun), 32'(1));
    chk("t3_busy", 32'(busy), 32'(0));
    go(); sin_vld = 1'b0; clr_ovr = 1'b1;
    go(); clr_ovr = 1'b0;
    probe();
    chk("t3_ovr_cleared", 32'(overrun), 32'(0));
    chk("t3_dout_after_clr", 32'(dout), 32'(4'hB));

    // Ready rises exactly as the next word completes: swap with no overrun.
    for (int i = 3; i >= 0; i--) begin
      send_bit(((4'h6 >> i) & 4'h1) != 0, (i == 3));
      if (i == 0) begin
        dout_rdy = 1'b1;
        sb.push_back(4'h6);
      end
    end
    go(); sin_vld = 1'b0; sof = 1'b0;
    probe();
    chk("t4_dout", 32'(dout), 32'(4'h6));
    chk("t4_vld", 32'(dout_vld), 32'(1));
    chk("t4_overrun", 32'(overrun), 32'(0));
    idle(3);

    // Abandoned partial frame followed by sof resync.
    sb.push_back(4'hC);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_frame(4'hC, 1'b1);
    idle(4);
    chk("t5_drain", 32'(sb.size()), 32'(0));

    // Reset mid-frame with an undelivered word held.
    dout_rdy = 1'b0;
    send_frame(4'hA, 1'b1);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    go(); sin_vld = 1'b0; sof = 1'b0; rst = 1'b1;
    go(); rst = 1'b0;
    probe();
    chk("t6_busy", 32'(busy), 32'(0));
    chk("t6_vld", 32'(dout_vld), 32'(0));
    chk("t6_dout", 32'(dout), 32'(0));
    dout_rdy = 1'b1;
    sb.push_back(4'h9);
    send_frame(4'h9, 1'b0);
    idle(1);
    probe();
    chk("t6_dout_after", 32'(dout), 32'(4'h9));
    idle(4);
    chk("final_drain", 32'(sb.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/sipo_deser.md
SIPO_DESER -- requirements
Module: sipo_deser

Interface
REQ-001 SHALL have parameter WIDTH, default 4, parallel word width in bits; legal range 2..32.
REQ-002 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-003 SHALL have port rst, input, 1, reset; rst is synchronous, active-high; clock is clk.
REQ-004 SHALL have port sin, input, 1, serial data bit, MSB first.
REQ-005 SHALL have port sin_vld, input, 1, sin is sampled only in cycles where sin_vld=1.
REQ-006 SHALL have port sof, input, 1, start-of-frame; qualified by sin_vld; marks the MSB bit.
REQ-007 SHALL have port dout, output, WIDTH, assembled parallel word.
REQ-008 SHALL have port dout_vld, output, 1, dout holds an undelivered word.
REQ-009 SHALL have port dout_rdy, input, 1, consumer accepts dout when dout_vld=1 and dout_rdy=1.
REQ-010 SHALL have port busy, output, 1, partial word in progress (state SHIFT).
REQ-011 SHALL have port overrun, output, 1, sticky: a completed word was dropped.
REQ-012 SHALL have port clr_ovr, input, 1, clears overrun.

Function
REQ-013 SHALL implement FSM states IDLE (bit count 0) and SHIFT (1..WIDTH-1 bits held).
REQ-014 SHALL, on sin_vld=1 without sof, shift: shreg <= {shreg[WIDTH-2:0], sin}, count +1; IDLE->SHIFT on first bit.
REQ-015 SHALL, on sin_vld=1 with sof=1 in any state, discard any partial word, load sin as MSB, set count=1, enter SHIFT.
REQ-016 SHALL hold shreg, count and state unchanged when sin_vld=0; sof ignored when sin_vld=0.
REQ-017 SHALL, when the WIDTH-th bit is accepted, form word {shreg[WIDTH-2:0], sin}, reset count to 0, return to IDLE.
REQ-018 SHALL present a completed word on dout with dout_vld=1 exactly one cycle after the clock edge sampling its last bit.
REQ-019 SHALL keep dout stable and dout_vld=1 while dout_vld=1 and dout_rdy=0.
REQ-020 SHALL clear dout_vld the cycle after a handshake unless a new word completes in the handshake cycle.
REQ-021 SHALL, when a word completes in the same cycle as a handshake, load the new word and keep dout_vld=1 with no overrun.
REQ-022 SHALL, when a word completes while dout_vld=1 and dout_rdy=0, drop the new word, keep dout, set overrun.
REQ-023 SHALL clear overrun on clr_ovr=1; if set and clear coincide, set wins.
REQ-024 SHALL not use dout_rdy in any combinational path to dout_vld or dout.
REQ-025 SHALL accept a new frame's first bit in the cycle after the previous frame's last bit (no dead cycle).

Reset
REQ-026 SHALL, on rst=1 at a clk edge, set state IDLE, count 0, shreg 0, dout 0, dout_vld 0, busy 0, overrun 0.
REQ-027 SHALL give rst priority over all inputs; a partial word or undelivered dout is discarded.

Structure
REQ-028 SHALL place the FSM state typedef (IDLE, SHIFT) and the count width constant $clog2(WIDTH+1) in shared package sipo_pkg.
REQ-029 SHALL implement the output holding register and handshake in one sub-module, sipo_hold_reg; shift/count/FSM in sipo_deser.

Verification (WIDTH=4)
REQ-030 SHALL cover: reset, sof with bits 1,0,1,1 on 4 consecutive cycles, dout_rdy=1 -> dout=4'hB, dout_vld high exactly 1 cycle, busy high for 3 cycles.
REQ-031 SHALL cover: bits 0,1,1,0 with 2 idle cycles between each bit -> dout=4'h6, dout_vld only after the 4th bit, state held during gaps.
REQ-032 SHALL cover: dout_rdy=0, frames 4'hB then 4'h6 back-to-back -> dout stays 4'hB, overrun=1; clr_ovr pulse -> overrun=0.
REQ-033 SHALL cover: 4'hB held, dout_rdy=1 in the cycle the last bit of 4'h6 arrives -> next cycle dout=4'h6, dout_vld=1, overrun=0.
REQ-034 SHALL cover: 2 bits sent, then sof with bits 1,1,0,0 -> dout=4'hC; abandoned bits have no effect.
REQ-035 SHALL cover: rst after 2 bits of a frame -> busy=0, dout_vld=0, dout=0; next frame 1,0,0,1 -> dout=4'h9.
